// File: rtl/max_pool_unit.sv
// Multi-channel max-pooling engine: per-channel running max and argmax over WIN beats,
// valid/ready on both sides, signed/unsigned compare latched on each window's first beat.
module max_pool_unit #(
  parameter int DATA_W = 8,
  parameter int CH     = 4,
  parameter int WIN    = 4,
  parameter int IDX_W  = (WIN > 2) ? $clog2(WIN) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                signed_mode,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH*DATA_W-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH*DATA_W-1:0] out_data,
  output logic [CH*IDX_W-1:0]  out_idx,
  output logic [IDX_W-1:0]     win_cnt
);

  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(WIN - 1);

  logic [IDX_W-1:0] cnt_reg;
  logic             mode_reg;
  logic             out_valid_reg;
  logic             accept;
  logic             first_beat;
  logic             last_beat;
  logic             cmp_signed;

  // Backpressure is conservative: any unconsumed result stalls the input side.
  assign in_ready   = !clear && !(out_valid_reg && !out_ready);
  assign accept     = in_valid && in_ready;
  assign first_beat = (cnt_reg == '0);
  assign last_beat  = (cnt_reg == LAST_BEAT);
  // The first beat of a window compares nothing, but its mode must already govern WIN=1 loads.
  assign cmp_signed = first_beat ? signed_mode : mode_reg;

  assign out_valid = out_valid_reg;
  assign win_cnt   = cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg       <= '0;
      mode_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      if (clear) begin
        cnt_reg <= '0;
      end else if (accept) begin
        if (first_beat) begin
          mode_reg <= signed_mode;
        end
        if (last_beat) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      // A fresh result wins over consumption of the old one in the same cycle.
      if (accept && last_beat) begin
        out_valid_reg <= 1'b1;
      end else if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic [DATA_W-1:0] sample;
      logic [DATA_W-1:0] max_reg;
      logic [DATA_W-1:0] max_next;
      logic [IDX_W-1:0]  idx_reg;
      logic [IDX_W-1:0]  idx_next;
      logic [DATA_W-1:0] res_max_reg;
      logic [IDX_W-1:0]  res_idx_reg;
      logic              greater;

      assign sample = in_data[gi*DATA_W +: DATA_W];

      always_comb begin
        greater  = 1'b0;
        max_next = max_reg;
        idx_next = idx_reg;
        if (cmp_signed) begin
          greater = ($signed(sample) > $signed(max_reg));
        end else begin
          greater = (sample > max_reg);
        end
        if (first_beat) begin
          max_next = sample;
          idx_next = '0;
        end else if (greater) begin
          max_next = sample;
          idx_next = cnt_reg;
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          max_reg     <= '0;
          idx_reg     <= '0;
          res_max_reg <= '0;
          res_idx_reg <= '0;
        end else if (accept) begin
          max_reg <= max_next;
          idx_reg <= idx_next;
          if (last_beat) begin
            res_max_reg <= max_next;
            res_idx_reg <= idx_next;
          end
        end
      end

      assign out_data[gi*DATA_W +: DATA_W] = res_max_reg;
      assign out_idx[gi*IDX_W +: IDX_W]    = res_idx_reg;
    end
  endgenerate

endmodule

// File: tb/tb_max_pool_unit.sv
// Self-checking bench for max_pool_unit: fixed vector table, hand-written corner sequences,
// and randomized traffic checked against a window-level reference model.
module tb_max_pool_unit;

  localparam int DW  = 8;
  localparam int CH  = 4;
  localparam int WIN = 4;
  localparam int IW  = 2;

  logic              clk;
  logic              rst;
  logic              clear;
  logic              signed_mode;
  logic              in_valid;
  logic              in_ready;
  logic [CH*DW-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CH*DW-1:0]  out_data;
  logic [CH*IW-1:0]  out_idx;
  logic [IW-1:0]     win_cnt;

  max_pool_unit #(.DATA_W(DW), .CH(CH), .WIN(WIN), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .clear(clear), .signed_mode(signed_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .win_cnt(win_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int results = 0;

  // Reference model: beats of the open window, latched mode, pending result.
  logic [CH*DW-1:0] win_q[$];
  bit               m_mode;
  bit               m_valid;
  logic [CH*DW-1:0] m_data;
  logic [CH*IW-1:0] m_idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    win_q.delete();
    m_mode  = 1'b0;
    m_valid = 1'b0;
    m_data  = '0;
    m_idx   = '0;
  endtask

  // Max over the whole stored window; strict > keeps the earliest index on ties.
  task automatic model_result();
    for (int c = 0; c < CH; c++) begin
      logic [DW-1:0] best;
      logic [DW-1:0] s;
      int bi;
      bit gt;
      best = win_q[0][c*DW +: DW];
      bi = 0;
      for (int k = 1; k < win_q.size(); k++) begin
        s = win_q[k][c*DW +: DW];
        gt = m_mode ? ($signed(s) > $signed(best)) : (s > best);
        if (gt) begin
          best = s;
          bi = k;
        end
      end
      m_data[c*DW +: DW] = best;
      m_idx[c*IW +: IW]  = IW'(bi);
    end
  endtask

  // One clock cycle: drive, check in_ready, clock, advance model, check outputs.
  task automatic cycle(input bit v, input logic [CH*DW-1:0] d, input bit md,
                       input bit ordy, input bit clr);
    bit exp_rdy;
    bit acc;
    in_valid = v;
    in_data = d;
    signed_mode = md;
    out_ready = ordy;
    clear = clr;
    #1;
    exp_rdy = !clr && !(m_valid && !ordy);
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    acc = v && exp_rdy;
    @(posedge clk);
    if (acc) begin
      if (win_q.size() == 0) m_mode = md;
      win_q.push_back(d);
      if (win_q.size() == WIN) begin
        model_result();
        m_valid = 1'b1;
        win_q.delete();
        results++;
        $display("result %0d mode=%0d data=%h idx=%h", results, m_mode, m_data, m_idx);
      end else if (m_valid && ordy) begin
        m_valid = 1'b0;
      end
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
    if (clr) win_q.delete();
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("out_data", out_data, m_data);
    chk("out_idx", {24'd0, out_idx}, {24'd0, m_idx});
    chk("win_cnt", {30'd0, win_cnt}, 32'(win_q.size()));
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  typedef struct packed {
    logic               mode;
    logic [3:0][31:0]   beats;
    logic [31:0]        exp_data;
    logic [7:0]         exp_idx;
  } vec_t;

  vec_t tv[4];
  logic [31:0] held;
  logic [31:0] rd;

  initial begin
    // Vector: mode on first beat (later beats use the opposite), beats {b3,b2,b1,b0}, expected.
    tv[0] = '{mode: 1'b0,
              beats: {32'h0000FF01, 32'h0000FF09, 32'h0000FF09, 32'h0000FF03},
              exp_data: 32'h0000FF09, exp_idx: 8'h01};
    tv[1] = '{mode: 1'b1,
              beats: {32'h057F0001, 32'h0580FFFF, 32'h05FE817F, 32'h05FF8080},
              exp_data: 32'h057F007F, exp_idx: 8'h3D};
    tv[2] = '{mode: 1'b0,
              beats: {32'h057F0001, 32'h0580FFFF, 32'h05FE817F, 32'h05FF8080},
              exp_data: 32'h05FFFFFF, exp_idx: 8'h0A};
    tv[3] = '{mode: 1'b0,
              beats: {32'h7F001040, 32'h80002030, 32'h80003020, 32'h7F004010},
              exp_data: 32'h80004040, exp_idx: 8'h43};

    rst = 1'b0;
    clear = 1'b0;
    signed_mode = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    model_reset();
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_idx", {24'd0, out_idx}, 32'd0);
    chk("rst_win_cnt", {30'd0, win_cnt}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven windows.
    for (int i = 0; i < 4; i++) begin
      for (int b = 0; b < WIN; b++) begin
        cycle(1'b1, tv[i].beats[b], (b == 0) ? tv[i].mode : !tv[i].mode, 1'b1, 1'b0);
      end
      chk("vec_data", out_data, tv[i].exp_data);
      chk("vec_idx", {24'd0, out_idx}, {24'd0, tv[i].exp_idx});
      $display("vector %0d data=%h idx=%h", i, out_data, out_idx);
      idle();
      chk("vec_valid_one_cycle", {31'd0, out_valid}, 32'd0);
    end

    // Back-to-back: 12 beats, results after beats 4, 8, 12.
    for (int k = 0; k < 12; k++) begin
      rd = $urandom;
      cycle(1'b1, rd, 1'($urandom), 1'b1, 1'b0);
      chk("b2b_valid", {31'd0, out_valid}, {31'd0, (k % 4) == 3});
    end
    idle();

    // Backpressure: result pending, two beats offered and refused.
    for (int k = 0; k < WIN; k++) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    held = out_data;
    for (int k = 0; k < 2; k++) begin
      cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
      chk("bp_win_cnt", {30'd0, win_cnt}, 32'd0);
      chk("bp_hold", out_data, held);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("bp_consumed", {31'd0, out_valid}, 32'd0);
    cycle(1'b1, $urandom, 1'b0, 1'b1, 1'b0);
    chk("bp_resume", {30'd0, win_cnt}, 32'd1);
    for (int k = 1; k < WIN; k++) cycle(1'b1, $urandom, 1'b1, 1'b1, 1'b0);
    idle();

    // Clear after two beats; the clearing beat is refused.
    cycle(1'b1, $urandom, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, $urandom, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1);
    chk("clr_win_cnt", {30'd0, win_cnt}, 32'd0);
    for (int k = 0; k < WIN; k++) cycle(1'b1, $urandom, 1'b1, (k != WIN - 1), 1'b0);
    held = out_data;
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("clr_keeps_valid", {31'd0, out_valid}, 32'd1);
    chk("clr_keeps_data", out_data, held);
    idle();

    // Asynchronous reset with a result pending.
    for (int k = 0; k < WIN; k++) cycle(1'b1, 32'h11223344 + k, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_data", out_data, 32'd0);
    chk("arst_out_idx", {24'd0, out_idx}, 32'd0);
    chk("arst_win_cnt", {30'd0, win_cnt}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    #1;
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    #1;

    // Asynchronous reset mid-window.
    @(posedge clk);
    #1;
    cycle(1'b1, $urandom, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, $urandom, 1'b1, 1'b1, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_mid_win_cnt", {30'd0, win_cnt}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic against the reference model; small values provoke ties.
    for (int n = 0; n < 400; n++) begin
      rd = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h83838383) : $urandom;
      cycle($urandom_range(0, 3) != 0, rd, 1'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
